// File: rtl/spi_frame_packer.sv
`default_nettype none
// ============================================================================
// spi_frame_packer : snapshots NUM_CH player records and streams sync/seq/mask/payload/csum bytes
// Rev 1.0
// ============================================================================
module spi_frame_packer #(
  parameter int         NUM_CH    = 2,
  parameter int         CH_W      = 89,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [NUM_CH*CH_W-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]      ch_en_in,
  input  logic                   frame_req_in,
  output logic [7:0]             byte_out,
  output logic                   byte_valid_out,
  input  logic                   byte_ready_in,
  output logic                   busy_out,
  output logic                   frame_done_out,
  output logic [7:0]             seq_out,
  output logic [7:0]             overrun_count_out
);

  localparam int CH_BYTES   = (CH_W + 7) / 8;
  localparam int PAD_W      = CH_BYTES * 8;
  localparam int CH_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_IDX_W = (CH_BYTES > 1) ? $clog2(CH_BYTES) : 1;
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(CH_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_SEQ     = 3'd2,
    S_MASK    = 3'd3,
    S_PAYLOAD = 3'd4,
    S_CSUM    = 3'd5
  } state_t;

  state_t                  state_q;
  logic [NUM_CH*CH_W-1:0]  snap_data_q;
  logic [NUM_CH-1:0]       snap_en_q;
  logic [7:0]              seq_q;
  logic                    pending_q;
  logic [7:0]              overrun_q;
  logic [7:0]              csum_q;
  logic [CH_IDX_W-1:0]     ch_idx_q;
  logic [BYTE_IDX_W-1:0]   byte_idx_q;
  logic [7:0]              byte_q;
  logic                    valid_q;
  logic                    done_q;

  logic [7:0]              pay_bytes [NUM_CH][CH_BYTES];
  logic [7:0]              mask_byte;
  logic [7:0]              csum_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_d;
  logic [CH_IDX_W-1:0]     first_ch;
  logic [CH_IDX_W-1:0]     next_ch;
  logic                    first_ok;
  logic                    next_ok;
  logic                    xfer;

  // Byte 0 of each channel is the most significant byte of the zero-padded record.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PAD_W-1:0] pad;
    assign pad = PAD_W'(snap_data_q[k*CH_W +: CH_W]);
    for (genvar b = 0; b < CH_BYTES; b++) begin : g_byte
      assign pay_bytes[k][b] = pad[(CH_BYTES-1-b)*8 +: 8];
    end
  end

  always_comb begin
    first_ch = '0;
    first_ok = 1'b0;
    next_ch  = '0;
    next_ok  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap_en_q[i]) begin
        first_ch = CH_IDX_W'(i);
        first_ok = 1'b1;
      end
      if (snap_en_q[i] && (i > int'(ch_idx_q))) begin
        next_ch = CH_IDX_W'(i);
        next_ok = 1'b1;
      end
    end
  end

  always_comb begin
    mask_byte = '0;
    mask_byte[NUM_CH-1:0] = snap_en_q;
  end

  assign csum_d     = csum_q + byte_q;
  assign byte_idx_d = byte_idx_q + 1'b1;
  assign xfer       = valid_q & byte_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      snap_data_q <= '0;
      snap_en_q   <= '0;
      seq_q       <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= '0;
      csum_q      <= '0;
      ch_idx_q    <= '0;
      byte_idx_q  <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && frame_req_in) begin
        if (!pending_q)
          pending_q <= 1'b1;
        else if (overrun_q != 8'hFF)
          overrun_q <= overrun_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          // A request arriving together with a held pending one is served by this same snapshot.
          if (frame_req_in || pending_q) begin
            snap_data_q <= ch_data_in;
            snap_en_q   <= ch_en_in;
            pending_q   <= 1'b0;
            csum_q      <= '0;
            byte_q      <= SYNC_BYTE;
            valid_q     <= 1'b1;
            state_q     <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (xfer) begin
            byte_q  <= seq_q;
            state_q <= S_SEQ;
          end
        end
        S_SEQ: begin
          if (xfer) begin
            csum_q  <= csum_d;
            byte_q  <= mask_byte;
            state_q <= S_MASK;
          end
        end
        S_MASK: begin
          if (xfer) begin
            csum_q <= csum_d;
            if (first_ok) begin
              ch_idx_q   <= first_ch;
              byte_idx_q <= '0;
              byte_q     <= pay_bytes[first_ch][0];
              state_q    <= S_PAYLOAD;
            end else begin
              byte_q  <= csum_d;
              state_q <= S_CSUM;
            end
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            csum_q <= csum_d;
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_d;
              byte_q     <= pay_bytes[ch_idx_q][byte_idx_d];
            end else if (next_ok) begin
              ch_idx_q   <= next_ch;
              byte_idx_q <= '0;
              byte_q     <= pay_bytes[next_ch][0];
            end else begin
              byte_q  <= csum_d;
              state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            done_q <= 1'b1;
            seq_q  <= seq_q + 8'd1;
            // A held request restarts at once so valid never drops between frames.
            if (pending_q) begin
              snap_data_q <= ch_data_in;
              snap_en_q   <= ch_en_in;
              pending_q   <= 1'b0;
              csum_q      <= '0;
              byte_q      <= SYNC_BYTE;
              state_q     <= S_SYNC;
            end else begin
              byte_q  <= '0;
              valid_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_out          = byte_q;
  assign byte_valid_out    = valid_q;
  assign busy_out          = (state_q != S_IDLE);
  assign frame_done_out    = done_q;
  assign seq_out           = seq_q;
  assign overrun_count_out = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_packer.sv
`default_nettype none
// Directed bench for spi_frame_packer with 2 channels of 89 bits (12 payload bytes each).
module tb_spi_frame_packer;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 89;
  localparam logic [NUM_CH*CH_W-1:0] DATA_A =
    {89'h1_FEDC_BA98_7654_3210_0F1E_2D, 89'h0_0123_4567_89AB_CDEF_A55A_C3};
  localparam logic [NUM_CH*CH_W-1:0] DATA_B = {DATA_A[88:0], DATA_A[177:89]};

  logic                   clk_in = 1'b0;
  logic                   rst_n_in = 1'b0;
  logic [NUM_CH*CH_W-1:0] ch_data_in = '0;
  logic [NUM_CH-1:0]      ch_en_in = '0;
  logic                   frame_req_in = 1'b0;
  logic                   byte_ready_in = 1'b0;
  logic [7:0]             byte_out;
  logic                   byte_valid_out;
  logic                   busy_out;
  logic                   frame_done_out;
  logic [7:0]             seq_out;
  logic [7:0]             overrun_count_out;

  spi_frame_packer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SYNC_BYTE(8'hA5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ch_data_in(ch_data_in), .ch_en_in(ch_en_in),
    .frame_req_in(frame_req_in), .byte_out(byte_out), .byte_valid_out(byte_valid_out),
    .byte_ready_in(byte_ready_in), .busy_out(busy_out), .frame_done_out(frame_done_out),
    .seq_out(seq_out), .overrun_count_out(overrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  logic [7:0] exp_seq = 8'd0;
  logic [7:0] expq[$];

  logic [7:0] got[$];
  int         xfer_cyc[$];
  int         done_cyc[$];
  int         stall_err = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pb = 8'd0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Logs every transferred byte and done pulse; flags any change of a stalled byte.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (pv && !pr && (byte_valid_out !== 1'b1 || byte_out !== pb)) stall_err <= stall_err + 1;
      if (byte_valid_out && byte_ready_in) begin
        got.push_back(byte_out);
        xfer_cyc.push_back(cyc);
      end
      if (frame_done_out) done_cyc.push_back(cyc);
    end
    pv <= rst_n_in & byte_valid_out;
    pr <= byte_ready_in;
    pb <= byte_out;
  end

  function automatic void build_exp(input logic [NUM_CH*CH_W-1:0] d, input logic [1:0] m,
                                    input logic [7:0] s);
    logic [7:0]  sum;
    logic [95:0] pad;
    expq.delete();
    expq.push_back(8'hA5);
    expq.push_back(s);
    expq.push_back({6'b0, m});
    sum = s + {6'b0, m};
    for (int c = 0; c < NUM_CH; c++) begin
      if (m[c]) begin
        pad = 96'(d[c*CH_W +: CH_W]);
        for (int b = 0; b < 12; b++) begin
          expq.push_back(pad[95-8*b -: 8]);
          sum = sum + pad[95-8*b -: 8];
        end
      end
    end
    expq.push_back(sum);
  endfunction

  task automatic do_reset();
    byte_ready_in = 1'b0;
    frame_req_in  = 1'b0;
    rst_n_in      = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    exp_seq = 8'd0;
  endtask

  task automatic pulse_req();
    @(posedge clk_in);
    #1 frame_req_in = 1'b1;
    @(posedge clk_in);
    #1 req_cyc = cyc;
    frame_req_in = 1'b0;
  endtask

  task automatic run_until(input int n_abs, input bit rnd, input int budget);
    int c = 0;
    while (got.size() < n_abs && c < budget) begin
      @(posedge clk_in);
      #1 byte_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      c++;
    end
  endtask

  task automatic wait_idle();
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    total++; if (byte_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", byte_valid_out); end
    total++; if (byte_out !== 8'h00) begin bad++; $display("FAIL rst_byte: got %h want 00", byte_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_out); end
    total++; if (frame_done_out !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", frame_done_out); end
    total++; if (seq_out !== 8'h00) begin bad++; $display("FAIL rst_seq: got %h want 00", seq_out); end
    total++; if (overrun_count_out !== 8'h00) begin bad++; $display("FAIL rst_overrun: got %h want 00", overrun_count_out); end
    do_reset();
  endtask

  task automatic test_full_frame();
    int base, d0, nerr;
    base = got.size(); d0 = done_cyc.size(); nerr = 0;
    ch_data_in = DATA_A; ch_en_in = 2'b11; byte_ready_in = 1'b1;
    build_exp(DATA_A, 2'b11, exp_seq);
    pulse_req();
    run_until(base + 28, 1'b0, 200);
    wait_idle();
    total++; if (got.size() - base !== 28) begin bad++; $display("FAIL t1_len: got %0d want 28", got.size() - base); end
    if (got.size() - base >= 28) begin
      for (int i = 0; i < 28; i++) if (got[base+i] !== expq[i]) nerr++;
      total++; if (nerr != 0) begin bad++; $display("FAIL t1_bytes: %0d bytes wrong, want 0", nerr); end
      total++; if (got[base+3] !== 8'h00 || got[base+4] !== 8'h01 || got[base+14] !== 8'hC3)
        begin bad++; $display("FAIL t1_ch0: got %h %h %h want 00 01 c3", got[base+3], got[base+4], got[base+14]); end
      total++; if (got[base+15] !== 8'h01 || got[base+16] !== 8'hFE || got[base+26] !== 8'h2D)
        begin bad++; $display("FAIL t1_ch1: got %h %h %h want 01 fe 2d", got[base+15], got[base+16], got[base+26]); end
      total++; if (xfer_cyc[base] !== req_cyc) begin bad++; $display("FAIL t1_latency: got cycle %0d want %0d", xfer_cyc[base], req_cyc); end
      total++; if (done_cyc.size() - d0 !== 1 || done_cyc[d0] !== xfer_cyc[base+27] + 1)
        begin bad++; $display("FAIL t1_done: got %0d pulses want 1 at cycle %0d", done_cyc.size() - d0, xfer_cyc[base+27] + 1); end
    end
    total++; if (seq_out !== 8'h01) begin bad++; $display("FAIL t1_seq: got %h want 01", seq_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL t1_idle: got %b want 0", busy_out); end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_backpressure();
    int base, s0, nerr;
    base = got.size(); s0 = stall_err; nerr = 0;
    build_exp(DATA_A, 2'b11, exp_seq);
    byte_ready_in = 1'($urandom_range(0, 1));
    pulse_req();
    run_until(base + 28, 1'b1, 600);
    byte_ready_in = 1'b1;
    wait_idle();
    total++; if (got.size() - base !== 28) begin bad++; $display("FAIL t2_len: got %0d want 28", got.size() - base); end
    if (got.size() - base >= 28) begin
      for (int i = 0; i < 28; i++) if (got[base+i] !== expq[i]) nerr++;
      total++; if (nerr != 0) begin bad++; $display("FAIL t2_bytes: %0d bytes wrong, want 0", nerr); end
    end
    total++; if (stall_err !== s0) begin bad++; $display("FAIL t2_stable: got %0d changes want 0", stall_err - s0); end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_masks();
    int base, nerr;
    base = got.size(); nerr = 0;
    ch_en_in = 2'b10;
    build_exp(DATA_A, 2'b10, exp_seq);
    pulse_req();
    run_until(base + 16, 1'b0, 200);
    wait_idle();
    total++; if (got.size() - base !== 16) begin bad++; $display("FAIL t3_len: got %0d want 16", got.size() - base); end
    if (got.size() - base >= 16) begin
      for (int i = 0; i < 16; i++) if (got[base+i] !== expq[i]) nerr++;
      total++; if (nerr != 0) begin bad++; $display("FAIL t3_bytes: %0d bytes wrong, want 0", nerr); end
      total++; if (got[base+2] !== 8'h02 || got[base+3] !== 8'h01)
        begin bad++; $display("FAIL t3_mask: got %h %h want 02 01", got[base+2], got[base+3]); end
    end
    exp_seq = exp_seq + 8'd1;
    base = got.size();
    ch_en_in = 2'b00;
    pulse_req();
    run_until(base + 4, 1'b0, 200);
    wait_idle();
    total++; if (got.size() - base !== 4) begin bad++; $display("FAIL t3_empty_len: got %0d want 4", got.size() - base); end
    if (got.size() - base >= 4) begin
      total++; if (got[base] !== 8'hA5 || got[base+1] !== exp_seq || got[base+2] !== 8'h00 || got[base+3] !== exp_seq)
        begin bad++; $display("FAIL t3_empty: got %h %h %h %h want a5 %h 00 %h", got[base], got[base+1], got[base+2], got[base+3], exp_seq, exp_seq); end
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_back_to_back();
    int base, d0, nerr;
    logic [7:0] exp1[$];
    base = got.size(); d0 = done_cyc.size(); nerr = 0;
    ch_data_in = DATA_A; ch_en_in = 2'b11;
    build_exp(DATA_A, 2'b11, exp_seq);
    exp1 = expq;
    build_exp(DATA_B, 2'b01, exp_seq + 8'd1);
    pulse_req();
    for (int c = 0; c < 200 && got.size() < base + 44; c++) begin
      @(posedge clk_in);
      #1 frame_req_in = (c == 5 || c == 7 || c == 9);
      byte_ready_in = 1'b1;
      if (c == 3) begin ch_data_in = DATA_B; ch_en_in = 2'b01; end
    end
    frame_req_in = 1'b0;
    wait_idle();
    total++; if (got.size() - base !== 44) begin bad++; $display("FAIL t4_len: got %0d want 44", got.size() - base); end
    if (got.size() - base >= 44) begin
      for (int i = 0; i < 28; i++) if (got[base+i] !== exp1[i]) nerr++;
      for (int i = 0; i < 16; i++) if (got[base+28+i] !== expq[i]) nerr++;
      total++; if (nerr != 0) begin bad++; $display("FAIL t4_bytes: %0d bytes wrong, want 0", nerr); end
      total++; if (xfer_cyc[base+28] !== xfer_cyc[base+27] + 1)
        begin bad++; $display("FAIL t4_gap: got cycle %0d want %0d", xfer_cyc[base+28], xfer_cyc[base+27] + 1); end
    end
    total++; if (overrun_count_out !== 8'd2) begin bad++; $display("FAIL t4_overrun: got %0d want 2", overrun_count_out); end
    total++; if (done_cyc.size() - d0 !== 2) begin bad++; $display("FAIL t4_done: got %0d want 2", done_cyc.size() - d0); end
    exp_seq = exp_seq + 8'd2;
    total++; if (seq_out !== exp_seq) begin bad++; $display("FAIL t4_seq: got %h want %h", seq_out, exp_seq); end
  endtask

  task automatic test_seq_wrap();
    int base, d0, nerr;
    do_reset();
    base = got.size(); d0 = done_cyc.size(); nerr = 0;
    ch_en_in = 2'b00;
    for (int f = 0; f < 256; f++) begin
      pulse_req();
      run_until(base + 4 * (f + 1), 1'b0, 50);
    end
    wait_idle();
    total++; if (got.size() - base !== 1024) begin bad++; $display("FAIL t5_len: got %0d want 1024", got.size() - base); end
    if (got.size() - base >= 1024) begin
      for (int f = 0; f < 256; f++)
        if (got[base+4*f] !== 8'hA5 || got[base+4*f+1] !== 8'(f) || got[base+4*f+3] !== 8'(f)) nerr++;
      total++; if (nerr != 0) begin bad++; $display("FAIL t5_frames: %0d frames wrong, want 0", nerr); end
      total++; if (got[base+1021] !== 8'hFF) begin bad++; $display("FAIL t5_last_seq: got %h want ff", got[base+1021]); end
    end
    total++; if (seq_out !== 8'h00) begin bad++; $display("FAIL t5_wrap: got %h want 00", seq_out); end
    total++; if (done_cyc.size() - d0 !== 256) begin bad++; $display("FAIL t5_done: got %0d want 256", done_cyc.size() - d0); end
    ch_en_in = 2'b11;
    byte_ready_in = 1'b0;
    pulse_req();
    for (int i = 0; i < 101; i++) pulse_req();
    total++; if (overrun_count_out !== 8'd100) begin bad++; $display("FAIL t5_overrun_mid: got %0d want 100", overrun_count_out); end
    for (int i = 0; i < 200; i++) pulse_req();
    total++; if (overrun_count_out !== 8'hFF) begin bad++; $display("FAIL t5_overrun_sat: got %0d want 255", overrun_count_out); end
    total++; if (byte_valid_out !== 1'b1 || byte_out !== 8'hA5)
      begin bad++; $display("FAIL t5_stalled: got %b %h want 1 a5", byte_valid_out, byte_out); end
  endtask

  task automatic test_reset_mid_frame();
    int base, d0, nerr;
    do_reset();
    ch_data_in = DATA_A; ch_en_in = 2'b11;
    base = got.size();
    pulse_req();
    run_until(base + 28, 1'b0, 200);
    wait_idle();
    total++; if (seq_out !== 8'h01) begin bad++; $display("FAIL t6_pre_seq: got %h want 01", seq_out); end
    base = got.size(); d0 = done_cyc.size();
    pulse_req();
    run_until(base + 7, 1'b0, 200);
    byte_ready_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    total++; if (byte_valid_out !== 1'b0) begin bad++; $display("FAIL t6_valid: got %b want 0", byte_valid_out); end
    total++; if (seq_out !== 8'h00 || busy_out !== 1'b0)
      begin bad++; $display("FAIL t6_state: got seq %h busy %b want 00 0", seq_out, busy_out); end
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    wait_idle();
    total++; if (done_cyc.size() !== d0) begin bad++; $display("FAIL t6_no_done: got %0d pulses want 0", done_cyc.size() - d0); end
    base = got.size(); nerr = 0;
    build_exp(DATA_A, 2'b11, 8'h00);
    pulse_req();
    run_until(base + 28, 1'b0, 200);
    wait_idle();
    total++; if (got.size() - base !== 28) begin bad++; $display("FAIL t6_len: got %0d want 28", got.size() - base); end
    if (got.size() - base >= 28) begin
      for (int i = 0; i < 28; i++) if (got[base+i] !== expq[i]) nerr++;
      total++; if (nerr != 0 || got[base+1] !== 8'h00)
        begin bad++; $display("FAIL t6_clean: %0d bytes wrong, seq byte %h want 0 and 00", nerr, got[base+1]); end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_masks();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
